care_input: RTL
===============

CARE_INPUT -- requirements
Module: care_input

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 270_000, is the number of consecutive stable cycles required to accept a button level (10 ms at 27 MHz).
REQ-002 Parameter COOLDOWN_CYCLES, default 13_500_000, is the number of lockout cycles after each fired action (0.5 s).
REQ-003 Parameter LFSR_SEED, default 16'hACE1, is the LFSR reset and recovery value.
REQ-004 Port clk, input, 1 bit: 27 MHz clock, the only clock.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port btn_next, input, 1 bit: raw asynchronous active-high button that advances the action cursor.
REQ-007 Port btn_ok, input, 1 bit: raw asynchronous active-high button that fires the selected action.
REQ-008 Port inputs, output, 8 bits: one-hot, single-cycle care-action pulses feeding the stats stage; bit i decrements stat i; bits 7:6 are always 0.
REQ-009 Port random, output, 3 bits: pseudo-random stat selector feeding the stats stage.
REQ-010 Port cursor, output, 3 bits: currently selected action index, 0..5, for the display.
REQ-011 Port busy, output, 1 bit: high in the FIRE and COOLDOWN states.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer followed by a debouncer.
- Debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
- Any bounce restarts the count.
REQ-013 A press event SHALL be a one-cycle pulse on the rising edge of the debounced level; releases generate no event.
REQ-014 Latency SHALL be exactly DEBOUNCE_CYCLES+4 clk edges, counted from the first edge that samples the raw button high, to the inputs pulse (for btn_ok) or the cursor update (for btn_next).
REQ-015 Control FSM states SHALL be IDLE, FIRE and COOLDOWN.
REQ-016 In IDLE, an ok event SHALL latch cursor into an action register and move to FIRE; no other transitions occur from IDLE.
REQ-017 In FIRE (exactly one cycle), inputs[action] SHALL be 1 and all other bits 0; the FSM then moves to COOLDOWN with the cooldown counter cleared.
REQ-018 In COOLDOWN, the counter SHALL increment each cycle; on reaching COOLDOWN_CYCLES-1, the FSM returns to IDLE.
REQ-019 Ok events arriving in FIRE or COOLDOWN SHALL be discarded, not queued.
REQ-020 A next event SHALL advance cursor in every state, wrapping 5 -> 0; cursor never takes the values 6 or 7.
REQ-021 When ok and next events occur in the same IDLE cycle, the fired action SHALL use the pre-advance cursor, and cursor SHALL advance in that same cycle.
REQ-022 Cursor changes during FIRE SHALL NOT alter the action being pulsed.
REQ-023 Outside FIRE, inputs SHALL be 8'h00.
REQ-024 The LFSR SHALL be 16 bits, Fibonacci, taps 16/14/13/11, and shift every cycle; random = lfsr[2:0].
REQ-025 If the LFSR state is ever 0, it SHALL reload LFSR_SEED on the next cycle.
REQ-026 Counters SHALL be sized with $clog2 of their parameter and SHALL never wrap past their terminal value.

Reset
REQ-027 While rst_n is low, the block SHALL hold:
- FSM in IDLE;
- inputs = 0, cursor = 0, busy = 0;
- synchronizers, debounced levels and all counters at 0;
- lfsr = LFSR_SEED, so random = 3'b001.
REQ-028 Reset assertion mid-FIRE or mid-COOLDOWN SHALL abort immediately with no inputs pulse.
REQ-029 After reset release, a button already held high SHALL produce a press event after the full debounce, because debounced levels restart at 0.

Structure
REQ-030 A shared package (care_pkg) SHALL hold:
- NUM_ACTIONS = 6;
- action index constants HUNGER = 0, HAPPINESS = 1, HEALTH = 2, HYGIENE = 3, ENERGY = 4, SOCIAL = 5;
- the FSM state enum.
REQ-031 One sub-module, debounce (synchronizer, debouncer and rising-edge detector), SHALL be instantiated twice.

Verification (DEBOUNCE_CYCLES = 4, COOLDOWN_CYCLES = 8)
REQ-032 btn_ok held high from a reset state -> inputs = 8'h01 for exactly one cycle, 8 edges after the first high sample; busy high for 9 cycles.
REQ-033 btn_next pressed 7 times with clean 20-cycle presses -> cursor sequence 1, 2, 3, 4, 5, 0, 1; then ok -> inputs = 8'h02.
REQ-034 btn_ok bouncing (high 2 cycles, low 1 cycle, repeated) then stable high -> exactly one pulse, 8 edges after stable high begins.
REQ-035 Second ok press landing mid-COOLDOWN -> no second pulse; an ok press after busy falls -> pulse.
REQ-036 Ok and next events in the same cycle with cursor = 5 -> inputs = 8'h20 and cursor = 0.
REQ-037 rst_n pulsed low during COOLDOWN -> busy drops asynchronously, inputs stays 0, random = 1 and lfsr = 16'hACE1 after reset; random never stalls (no constant run longer than 16 cycles).

Source files
------------

// File: rtl/care_pkg.sv
// Shared definitions for the care-input path: action indices, FSM state
// encoding and the cursor advance helper.
package care_pkg;

  localparam int NUM_ACTIONS = 6;

  localparam logic [2:0] HUNGER    = 3'd0;
  localparam logic [2:0] HAPPINESS = 3'd1;
  localparam logic [2:0] HEALTH    = 3'd2;
  localparam logic [2:0] HYGIENE   = 3'd3;
  localparam logic [2:0] ENERGY    = 3'd4;
  localparam logic [2:0] SOCIAL    = 3'd5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRE     = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  // Cursor wraps after the last action so it never reaches 6 or 7.
  function automatic logic [2:0] next_cursor(input logic [2:0] c);
    if (c >= 3'(NUM_ACTIONS - 1)) return 3'd0;
    else return c + 3'd1;
  endfunction

endpackage

// File: rtl/care_input_debounce.sv
// debounce: 2-flop synchronizer, stable-level debouncer and rising-edge
// detector for one raw button.
//   clk, rst_n : clock, async active-low reset
//   btn        : raw asynchronous active-high button
//   press      : one-cycle pulse on the debounced rising edge
module debounce #(
  parameter int DEBOUNCE_CYCLES = 270_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[0], btn};
      level_d <= level;
      // Registered edge pulse: keeps the path to the FSM short and fixes
      // the end-to-end latency at DEBOUNCE_CYCLES+4.
      press   <= level & ~level_d;
      // cnt tracks how many consecutive cycles the synced input has
      // disagreed with level; any agreement (bounce) restarts it.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/care_input.sv
// care_input: turns two raw buttons into care-action pulses for the stats
// stage. "next" moves a cursor over the six actions; "ok" fires the
// selected action once, followed by a lockout. Also supplies a free-running
// pseudo-random stat selector.
//   clk, rst_n : 27 MHz clock, async active-low reset
//   btn_next   : raw button, advances cursor
//   btn_ok     : raw button, fires cursor action
//   inputs     : one-hot single-cycle action pulse (bits 7:6 always 0)
//   random     : lfsr[2:0]
//   cursor     : selected action 0..5
//   busy       : high in FIRE and COOLDOWN
module care_input
  import care_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 270_000,
  parameter int          COOLDOWN_CYCLES = 13_500_000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic       btn_ok,
  output logic [7:0] inputs,
  output logic [2:0] random,
  output logic [2:0] cursor,
  output logic       busy
);
  localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [CW-1:0] CD_TERM = CW'(COOLDOWN_CYCLES - 1);

  logic          next_ev;
  logic          ok_ev;
  state_t        state;
  state_t        state_nx;
  logic [2:0]    action;
  logic [CW-1:0] cd_cnt;
  logic [15:0]   lfsr;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .rst_n(rst_n), .btn(btn_next), .press(next_ev)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ok (
    .clk(clk), .rst_n(rst_n), .btn(btn_ok), .press(ok_ev)
  );

  // Ok events outside IDLE simply fall through: nothing is queued.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (ok_ev) state_nx = FIRE;
      FIRE:     state_nx = COOLDOWN;
      COOLDOWN: if (cd_cnt == CD_TERM) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      action <= 3'd0;
      cursor <= 3'd0;
      cd_cnt <= '0;
    end else begin
      state <= state_nx;
      // action samples the pre-advance cursor, so a simultaneous next
      // press moves the cursor without changing what fires.
      if (state == IDLE && ok_ev) action <= cursor;
      if (next_ev) cursor <= next_cursor(cursor);
      if (state == FIRE) cd_cnt <= '0;
      else if (state == COOLDOWN && cd_cnt != CD_TERM) cd_cnt <= cd_cnt + 1'b1;
    end
  end

  always_comb begin
    inputs = 8'h00;
    if (state == FIRE) inputs[action] = 1'b1;
  end

  assign busy = (state != IDLE);

  // Fibonacci LFSR, taps 16/14/13/11; the all-zero lockup state reloads
  // the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (lfsr == 16'h0000) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign random = lfsr[2:0];

endmodule
